// File: rtl/tile_sprite_compositor.sv
// Tile-map + sprite pixel compositor with internal map RAM and clear sweep; RGB valid 2 cycles after DrawX/DrawY.
// No backpressure: accepts one pixel every cycle; map writes are dropped while the clear sweep runs.
module tile_sprite_compositor #(
   parameter  int NUM_SPRITES = 4,
   parameter  int TILE_LOG2   = 5,
   parameter  int MAP_W       = 20,
   parameter  int MAP_H       = 15,
   localparam int TC_W        = 10 - TILE_LOG2,
   localparam int MAP_N       = MAP_W * MAP_H,
   localparam int AW          = $clog2(MAP_N)
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic [9:0]                  DrawX,
   input  logic [9:0]                  DrawY,
   input  logic                        blank,
   input  logic                        frame_start,
   input  logic [NUM_SPRITES*TC_W-1:0] spr_x_in,
   input  logic [NUM_SPRITES*TC_W-1:0] spr_y_in,
   input  logic [NUM_SPRITES-1:0]      spr_en_in,
   input  logic [NUM_SPRITES-1:0]      spr_above_in,
   input  logic [NUM_SPRITES*24-1:0]   spr_rgb_in,
   input  logic [NUM_SPRITES-1:0]      spr_pixel,
   input  logic                        pixel_brk,
   input  logic                        map_we,
   input  logic [AW-1:0]               map_waddr,
   input  logic [2:0]                  map_wdata,
   input  logic                        map_clear,
   output logic                        clear_busy,
   output logic [7:0]                  Red,
   output logic [7:0]                  Green,
   output logic [7:0]                  Blue
);

   typedef enum logic {IDLE, CLEAR} clr_state_t;

   clr_state_t state, state_n;
   logic [AW-1:0] clr_addr, clr_addr_n;

   logic [2:0] map_mem [MAP_N];

   logic [NUM_SPRITES*TC_W-1:0] sh_x, sh_y;
   logic [NUM_SPRITES-1:0]      sh_en, sh_above;
   logic [NUM_SPRITES*24-1:0]   sh_rgb;

   logic [TC_W-1:0]        col, row;
   logic                   oom;
   logic [AW-1:0]          raddr;
   logic [NUM_SPRITES-1:0] hit;

   logic [2:0]             code_q;
   logic [NUM_SPRITES-1:0] hit_q;
   logic                   blank_q;

   logic        above_hit, below_hit;
   logic [23:0] above_rgb, below_rgb, pix_rgb, rgb_q;

   logic unused_sub_tile;
   assign unused_sub_tile = ^{DrawX[TILE_LOG2-1:0], DrawY[TILE_LOG2-1:0]};

   // Clear sweep: one tile per cycle, map_clear always restarts from tile 0.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state    <= CLEAR;
         clr_addr <= '0;
      end else begin
         state    <= state_n;
         clr_addr <= clr_addr_n;
      end
   end

   always_comb begin
      state_n    = state;
      clr_addr_n = clr_addr;
      if (map_clear) begin
         state_n    = CLEAR;
         clr_addr_n = '0;
      end else if (state == CLEAR) begin
         if (clr_addr == AW'(MAP_N - 1)) begin
            state_n    = IDLE;
            clr_addr_n = '0;
         end else begin
            clr_addr_n = clr_addr + 1'b1;
         end
      end
   end

   assign clear_busy = (state == CLEAR);

   always_ff @(posedge Clk) begin
      if (clear_busy)
         map_mem[clr_addr] <= 3'd0;
      else if (map_we && (int'(map_waddr) < MAP_N))
         map_mem[map_waddr] <= map_wdata;
   end

   // Sprite state only moves at frame boundaries so a frame never tears.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sh_x     <= '0;
         sh_y     <= '0;
         sh_en    <= '0;
         sh_above <= '0;
         sh_rgb   <= '0;
      end else if (frame_start) begin
         sh_x     <= spr_x_in;
         sh_y     <= spr_y_in;
         sh_en    <= spr_en_in;
         sh_above <= spr_above_in;
         sh_rgb   <= spr_rgb_in;
      end
   end

   assign col   = DrawX[9:TILE_LOG2];
   assign row   = DrawY[9:TILE_LOG2];
   assign oom   = (int'(col) >= MAP_W) || (int'(row) >= MAP_H);
   assign raddr = AW'(int'(row) * MAP_W + int'(col));

   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_SPRITES; i++)
         hit[i] = sh_en[i] && (sh_x[i*TC_W +: TC_W] == col) && (sh_y[i*TC_W +: TC_W] == row);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         code_q  <= 3'd0;
         hit_q   <= '0;
         blank_q <= 1'b1;
      end else begin
         code_q  <= (oom || clear_busy) ? 3'd0 : map_mem[raddr];
         hit_q   <= hit;
         blank_q <= blank;
      end
   end

   // Descending scan so the lowest-index sprite wins within each priority class.
   always_comb begin
      above_hit = 1'b0;
      below_hit = 1'b0;
      above_rgb = 24'h000000;
      below_rgb = 24'h000000;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (hit_q[i] && spr_pixel[i]) begin
            if (sh_above[i]) begin
               above_hit = 1'b1;
               above_rgb = sh_rgb[i*24 +: 24];
            end else begin
               below_hit = 1'b1;
               below_rgb = sh_rgb[i*24 +: 24];
            end
         end
      end

      pix_rgb = 24'h000000;
      if (blank_q) begin
         pix_rgb = 24'h000000;
      end else if (above_hit) begin
         pix_rgb = above_rgb;
      end else begin
         case (code_q)
            3'd0:    pix_rgb = below_hit ? below_rgb : 24'h000000;
            3'd1:    pix_rgb = 24'h505050;
            3'd2:    pix_rgb = pixel_brk ? 24'h964B00 : 24'h421010;
            3'd3,
            3'd4:    pix_rgb = 24'hFFD700;
            default: pix_rgb = 24'h000000;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) rgb_q <= 24'h000000;
      else       rgb_q <= pix_rgb;
   end

   assign Red   = rgb_q[23:16];
   assign Green = rgb_q[15:8];
   assign Blue  = rgb_q[7:0];

endmodule

// File: tb/tb_tile_sprite_compositor.sv
// Directed bench for tile_sprite_compositor with default parameters (4 sprites, 32x32 tiles, 20x15 map).
module tb_tile_sprite_compositor;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [9:0]  DrawX, DrawY;
   logic        blank;
   logic        frame_start;
   logic [19:0] spr_x_in, spr_y_in;
   logic [3:0]  spr_en_in, spr_above_in;
   logic [95:0] spr_rgb_in;
   logic [3:0]  spr_pixel;
   logic        pixel_brk;
   logic        map_we;
   logic [8:0]  map_waddr;
   logic [2:0]  map_wdata;
   logic        map_clear;
   logic        clear_busy;
   logic [7:0]  Red, Green, Blue;

   int total = 0;
   int bad   = 0;

   tile_sprite_compositor dut (
      .Clk(Clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .frame_start(frame_start), .spr_x_in(spr_x_in), .spr_y_in(spr_y_in),
      .spr_en_in(spr_en_in), .spr_above_in(spr_above_in), .spr_rgb_in(spr_rgb_in),
      .spr_pixel(spr_pixel), .pixel_brk(pixel_brk), .map_we(map_we),
      .map_waddr(map_waddr), .map_wdata(map_wdata), .map_clear(map_clear),
      .clear_busy(clear_busy), .Red(Red), .Green(Green), .Blue(Blue)
   );

   always #5 Clk = ~Clk;

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   // Pixel coordinates in one cycle, sprite/brick bits the next, RGB after the second edge.
   task automatic present(input logic [9:0] x, input logic [9:0] y, input logic b,
                          input logic [3:0] sp, input logic brk, output logic [23:0] rgb);
      DrawX = x; DrawY = y; blank = b;
      tick();
      spr_pixel = sp; pixel_brk = brk;
      tick();
      rgb = {Red, Green, Blue};
   endtask

   task automatic map_write(input logic [8:0] a, input logic [2:0] d);
      map_we = 1'b1; map_waddr = a; map_wdata = d;
      tick();
      map_we = 1'b0;
   endtask

   task automatic pulse_frame;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic test_reset;
      int n;
      logic [23:0] rgb;
      Reset = 1'b1;
      repeat (3) tick();
      total++;
      if ({Red, Green, Blue} !== 24'h000000) begin
         bad++; $display("FAIL reset_rgb got=%h exp=000000", {Red, Green, Blue});
      end
      total++;
      if (clear_busy !== 1'b1) begin
         bad++; $display("FAIL reset_busy got=%b exp=1", clear_busy);
      end
      Reset = 1'b0;
      n = 0;
      while (clear_busy && n < 1000) begin
         tick();
         n++;
      end
      total++;
      if (n !== 300) begin
         bad++; $display("FAIL reset_sweep_len got=%0d exp=300", n);
      end
      present(10'd40, 10'd40, 1'b0, 4'b0000, 1'b0, rgb);
      total++;
      if (rgb !== 24'h000000) begin
         bad++; $display("FAIL cleared_tile21 got=%h exp=000000", rgb);
      end
      present(10'd639, 10'd479, 1'b0, 4'b0000, 1'b1, rgb);
      total++;
      if (rgb !== 24'h000000) begin
         bad++; $display("FAIL cleared_tile299 got=%h exp=000000", rgb);
      end
   endtask

   task automatic test_map_colours;
      logic [23:0] rgb;
      map_write(9'd21, 3'd1);
      present(10'd40, 10'd40, 1'b0, 4'b0000, 1'b0, rgb);
      total++;
      if (rgb !== 24'h505050) begin
         bad++; $display("FAIL map_code1 got=%h exp=505050", rgb);
      end
      present(10'd40, 10'd40, 1'b1, 4'b0000, 1'b0, rgb);
      total++;
      if (rgb !== 24'h000000) begin
         bad++; $display("FAIL map_blank got=%h exp=000000", rgb);
      end
      // col 21 is off-map; an unchecked address would alias onto tile 21
      present(10'd700, 10'd0, 1'b0, 4'b0000, 1'b0, rgb);
      total++;
      if (rgb !== 24'h000000) begin
         bad++; $display("FAIL map_out_of_range got=%h exp=000000", rgb);
      end
      map_write(9'd22, 3'd4);
      present(10'd70, 10'd40, 1'b0, 4'b0000, 1'b0, rgb);
      total++;
      if (rgb !== 24'hFFD700) begin
         bad++; $display("FAIL map_code4 got=%h exp=FFD700", rgb);
      end
   endtask

   task automatic test_sprite_priority;
      logic [23:0] rgb;
      spr_x_in = {5'd0, 5'd1, 5'd1, 5'd1};
      spr_y_in = {5'd0, 5'd1, 5'd1, 5'd1};
      spr_en_in    = 4'b0111;
      spr_above_in = 4'b0001;
      spr_rgb_in   = {24'h123456, 24'h0000FF, 24'h005500, 24'hFFFFFF};
      pulse_frame();
      map_write(9'd21, 3'd2);
      present(10'd40, 10'd40, 1'b0, 4'b0011, 1'b0, rgb);
      total++;
      if (rgb !== 24'hFFFFFF) begin
         bad++; $display("FAIL spr_above_wins got=%h exp=FFFFFF", rgb);
      end
      present(10'd40, 10'd40, 1'b0, 4'b0010, 1'b1, rgb);
      total++;
      if (rgb !== 24'h964B00) begin
         bad++; $display("FAIL brick_lit got=%h exp=964B00", rgb);
      end
      present(10'd40, 10'd40, 1'b0, 4'b0010, 1'b0, rgb);
      total++;
      if (rgb !== 24'h421010) begin
         bad++; $display("FAIL brick_dark got=%h exp=421010", rgb);
      end
      map_write(9'd21, 3'd0);
      present(10'd40, 10'd40, 1'b0, 4'b0010, 1'b0, rgb);
      total++;
      if (rgb !== 24'h005500) begin
         bad++; $display("FAIL spr_below_empty got=%h exp=005500", rgb);
      end
      present(10'd40, 10'd40, 1'b0, 4'b0110, 1'b0, rgb);
      total++;
      if (rgb !== 24'h005500) begin
         bad++; $display("FAIL spr_below_lowest got=%h exp=005500", rgb);
      end
      present(10'd40, 10'd40, 1'b0, 4'b0100, 1'b0, rgb);
      total++;
      if (rgb !== 24'h0000FF) begin
         bad++; $display("FAIL spr2_alone got=%h exp=0000FF", rgb);
      end
      present(10'd40, 10'd40, 1'b0, 4'b0000, 1'b0, rgb);
      total++;
      if (rgb !== 24'h000000) begin
         bad++; $display("FAIL spr_transparent got=%h exp=000000", rgb);
      end
   endtask

   task automatic test_shadow_latch;
      logic [23:0] rgb;
      spr_x_in[9:5] = 5'd3;
      present(10'd40, 10'd40, 1'b0, 4'b0010, 1'b0, rgb);
      total++;
      if (rgb !== 24'h005500) begin
         bad++; $display("FAIL shadow_hold_old got=%h exp=005500", rgb);
      end
      present(10'd100, 10'd40, 1'b0, 4'b0010, 1'b0, rgb);
      total++;
      if (rgb !== 24'h000000) begin
         bad++; $display("FAIL shadow_not_new_yet got=%h exp=000000", rgb);
      end
      pulse_frame();
      present(10'd100, 10'd40, 1'b0, 4'b0010, 1'b0, rgb);
      total++;
      if (rgb !== 24'h005500) begin
         bad++; $display("FAIL shadow_new_tile got=%h exp=005500", rgb);
      end
      present(10'd40, 10'd40, 1'b0, 4'b0010, 1'b0, rgb);
      total++;
      if (rgb !== 24'h000000) begin
         bad++; $display("FAIL shadow_old_tile got=%h exp=000000", rgb);
      end
   endtask

   task automatic test_clear_sweep;
      int n;
      logic [23:0] rgb;
      map_write(9'd22, 3'd1);
      map_clear = 1'b1;
      tick();
      map_clear = 1'b0;
      total++;
      if (clear_busy !== 1'b1) begin
         bad++; $display("FAIL clear_start_busy got=%b exp=1", clear_busy);
      end
      // sweep has not reached tile 22 yet, reads must still be forced to 0
      present(10'd70, 10'd40, 1'b0, 4'b0000, 1'b0, rgb);
      total++;
      if (rgb !== 24'h000000) begin
         bad++; $display("FAIL read_while_busy got=%h exp=000000", rgb);
      end
      repeat (148) tick();
      map_clear = 1'b1;
      tick();
      map_clear = 1'b0;
      n = 0;
      while (clear_busy && n < 1000) begin
         if (n == 10) begin
            map_we = 1'b1; map_waddr = 9'd5; map_wdata = 3'd1;
         end else begin
            map_we = 1'b0;
         end
         tick();
         n++;
      end
      map_we = 1'b0;
      total++;
      if (n !== 300) begin
         bad++; $display("FAIL clear_restart_len got=%0d exp=300", n);
      end
      present(10'd160, 10'd0, 1'b0, 4'b0000, 1'b0, rgb);
      total++;
      if (rgb !== 24'h000000) begin
         bad++; $display("FAIL write_during_busy got=%h exp=000000", rgb);
      end
      map_write(9'd300, 3'd1);
      present(10'd639, 10'd479, 1'b0, 4'b0000, 1'b0, rgb);
      total++;
      if (rgb !== 24'h000000) begin
         bad++; $display("FAIL write_addr_300 got=%h exp=000000", rgb);
      end
   endtask

   task automatic test_same_cycle_rw;
      logic [23:0] rgb;
      map_write(9'd299, 3'd3);
      DrawX = 10'd639; DrawY = 10'd479; blank = 1'b0;
      map_we = 1'b1; map_waddr = 9'd299; map_wdata = 3'd1;
      tick();
      map_we = 1'b0; spr_pixel = 4'b0000; pixel_brk = 1'b0;
      tick();
      rgb = {Red, Green, Blue};
      total++;
      if (rgb !== 24'hFFD700) begin
         bad++; $display("FAIL rw_old_data got=%h exp=FFD700", rgb);
      end
      present(10'd639, 10'd479, 1'b0, 4'b0000, 1'b0, rgb);
      total++;
      if (rgb !== 24'h505050) begin
         bad++; $display("FAIL rw_new_data got=%h exp=505050", rgb);
      end
   endtask

   task automatic test_reset_midframe;
      logic [23:0] rgb;
      present(10'd100, 10'd40, 1'b0, 4'b0010, 1'b0, rgb);
      total++;
      if (rgb !== 24'h005500) begin
         bad++; $display("FAIL pre_reset_pixel got=%h exp=005500", rgb);
      end
      Reset = 1'b1;
      #1;
      total++;
      if ({Red, Green, Blue} !== 24'h000000) begin
         bad++; $display("FAIL midframe_reset_rgb got=%h exp=000000", {Red, Green, Blue});
      end
      tick();
      Reset = 1'b0;
      total++;
      if (clear_busy !== 1'b1) begin
         bad++; $display("FAIL midframe_reset_busy got=%b exp=1", clear_busy);
      end
      present(10'd100, 10'd40, 1'b0, 4'b0010, 1'b0, rgb);
      total++;
      if (rgb !== 24'h000000) begin
         bad++; $display("FAIL sprite_disabled_after_reset got=%h exp=000000", rgb);
      end
   endtask

   initial begin
      Reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b1; frame_start = 1'b0;
      spr_x_in = '0; spr_y_in = '0; spr_en_in = '0; spr_above_in = '0; spr_rgb_in = '0;
      spr_pixel = '0; pixel_brk = 1'b0; map_we = 1'b0; map_waddr = '0; map_wdata = '0;
      map_clear = 1'b0;
      test_reset();
      test_map_colours();
      test_sprite_priority();
      test_shadow_latch();
      test_clear_sweep();
      test_same_cycle_rw();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
